// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - pipeline boundary register with valid/ready, skid entry, flush bubble, stall; PIPE_STAT_EN adds stall/bubble counters
module pipe_stage_buf #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  NOP_VALUE = '0,
  parameter int unsigned       SKID      = 1,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             stall,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic             r_m_valid;
  logic [WIDTH-1:0] r_m_data;
  logic             r_s_valid;
  logic [WIDTH-1:0] r_s_data;

  logic w_in_ready;
  logic w_out_valid;
  logic w_in_fire;
  logic w_out_fire;

  // Upstream acceptance: skid mode only needs a free skid slot, single-entry
  // mode must see the main entry drain in the same cycle.
  always_comb begin
    w_in_ready = 1'b0;
    if (SKID != 0) begin
      w_in_ready = !r_s_valid && !stall && !flush && !RST;
    end else begin
      w_in_ready = (!r_m_valid || out_ready) && !stall && !flush && !RST;
    end
  end

  assign w_out_valid = r_m_valid && !stall;
  assign w_in_fire   = in_valid && w_in_ready;
  assign w_out_fire  = w_out_valid && out_ready;

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = r_m_data;
  assign occupancy = {1'b0, r_m_valid} + {1'b0, r_s_valid};

  // Entry update: reset > flush > stall > normal; skid always drains into main first
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
      r_m_data  <= NOP_VALUE;
      r_s_data  <= NOP_VALUE;
    end else if (flush) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
      r_m_data  <= NOP_VALUE;
      r_s_data  <= NOP_VALUE;
    end else if (stall) begin
      r_m_valid <= r_m_valid;
    end else if (!r_m_valid || w_out_fire) begin
      if (r_s_valid) begin
        r_m_data  <= r_s_data;
        r_m_valid <= 1'b1;
        r_s_valid <= 1'b0;
      end else if (w_in_fire) begin
        r_m_data  <= in_data;
        r_m_valid <= 1'b1;
      end else begin
        r_m_valid <= 1'b0;
      end
    end else if (w_in_fire && (SKID != 0)) begin
      r_s_data  <= in_data;
      r_s_valid <= 1'b1;
    end
  end

`ifdef PIPE_STAT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  // Saturating statistics; flush deliberately leaves them intact
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (!w_out_valid && out_ready && !stall && (r_bubble_cnt != '1)) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
      end
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - bench for pipe_stage_buf (SKID=0, SKID=1, SKID=1 with 4-bit counters)
module tb_pipe_stage_buf;

  localparam logic [31:0] NOP = 32'hDEAD_0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;

  logic        ir0, ir1, ir2, ov0, ov1, ov2;
  logic [31:0] od0, od1, od2;
  logic [1:0]  oc0, oc1, oc2;
  logic [15:0] sc0, sc1, bc0, bc1;
  logic [3:0]  sc2, bc2;

  int n_asrt = 0;
  int n_fail = 0;

  // Reference model: per instance a FIFO of at most cap entries plus the
  // last value left in the output register.
  int          m_cnt[3];
  logic [31:0] m_ent[3][2];
  logic [31:0] m_hold[3];
  int          m_sc[3];
  int          m_bc[3];

  always #5 CLK = ~CLK;

  pipe_stage_buf #(.WIDTH(32), .NOP_VALUE(NOP), .SKID(0), .CNT_W(16)) u_dut0 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .stall(stall), .flush(flush),
    .occupancy(oc0), .stall_cnt(sc0), .bubble_cnt(bc0));

  pipe_stage_buf #(.WIDTH(32), .NOP_VALUE(NOP), .SKID(1), .CNT_W(16)) u_dut1 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .stall(stall), .flush(flush),
    .occupancy(oc1), .stall_cnt(sc1), .bubble_cnt(bc1));

  pipe_stage_buf #(.WIDTH(32), .NOP_VALUE(NOP), .SKID(1), .CNT_W(4)) u_dut2 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
    .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .stall(stall), .flush(flush),
    .occupancy(oc2), .stall_cnt(sc2), .bubble_cnt(bc2));

  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  function automatic logic exp_ready(input int k);
    logic room;
    room = (k != 0) ? (m_cnt[k] < 2) : (m_cnt[k] == 0 || out_ready);
    return room && !stall && !flush && !RST;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = 0; m_hold[k] = NOP; m_sc[k] = 0; m_bc[k] = 0;
    end
  endtask

  // One cycle: compare DUT against model with current inputs, advance model, move to next negedge
  task automatic cycle();
    logic [63:0] o_ir, o_ov, o_od, o_oc, o_sc, o_bc;
    logic e_ir, e_ov, e_of, e_if;
    int   cmax;
    #1;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin o_ir = 64'(ir0); o_ov = 64'(ov0); o_od = 64'(od0); o_oc = 64'(oc0); o_sc = 64'(sc0); o_bc = 64'(bc0); end
        1: begin o_ir = 64'(ir1); o_ov = 64'(ov1); o_od = 64'(od1); o_oc = 64'(oc1); o_sc = 64'(sc1); o_bc = 64'(bc1); end
        default: begin o_ir = 64'(ir2); o_ov = 64'(ov2); o_od = 64'(od2); o_oc = 64'(oc2); o_sc = 64'(sc2); o_bc = 64'(bc2); end
      endcase
      e_ir = exp_ready(k);
      e_ov = (m_cnt[k] > 0) && !stall;
      chk("in_ready",   k, o_ir, 64'(e_ir));
      chk("out_valid",  k, o_ov, 64'(e_ov));
      chk("out_data",   k, o_od, 64'((m_cnt[k] > 0) ? m_ent[k][0] : m_hold[k]));
      chk("occupancy",  k, o_oc, 64'(m_cnt[k]));
      chk("stall_cnt",  k, o_sc, 64'(m_sc[k]));
      chk("bubble_cnt", k, o_bc, 64'(m_bc[k]));

      e_of = e_ov && out_ready;
      e_if = in_valid && e_ir;
      cmax = (k == 2) ? 15 : 65535;
      if (RST) begin
        m_cnt[k] = 0; m_hold[k] = NOP; m_sc[k] = 0; m_bc[k] = 0;
      end else begin
`ifdef PIPE_STAT_EN
        if (stall && m_sc[k] < cmax) m_sc[k]++;
        if (!e_ov && out_ready && !stall && m_bc[k] < cmax) m_bc[k]++;
`endif
        if (flush) begin
          m_cnt[k] = 0; m_hold[k] = NOP;
        end else if (!stall) begin
          if (e_of) begin
            m_hold[k] = m_ent[k][0];
            m_ent[k][0] = m_ent[k][1];
            m_cnt[k]--;
          end
          if (e_if) begin
            m_ent[k][m_cnt[k]] = in_data;
            m_cnt[k]++;
          end
        end
      end
    end
    @(negedge CLK);
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic ordy, input logic st, input logic fl);
    in_valid = v; in_data = d; out_ready = ordy; stall = st; flush = fl;
    cycle();
  endtask

  initial begin
    model_reset();
    @(posedge CLK);
    @(negedge CLK);

    // reset held with upstream offering data
    drive(1'b1, 32'hAA, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hAA, 1'b0, 1'b0, 1'b0);
    RST = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // streaming 1..8 with downstream always ready
    for (int i = 1; i <= 8; i++) drive(1'b1, 32'(i), 1'b1, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // backpressure: A then B into skid, then drain
    drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // fill to two entries and flush with C offered
    drive(1'b1, 32'hA1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hB1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hC, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // stall with a held entry, then a long stall to saturate the narrow counter
    drive(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h66, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // single-entry sustained throughput with a backpressure bubble
    drive(1'b1, 32'h70, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h71, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b1, 32'h80 + 32'(i), 1'b1, 1'b0, 1'b0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      RST = ($urandom_range(0, 99) == 0);
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 19) == 0));
    end
    RST = 1'b0;
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
